div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Sequential signed 32-bit divider that produces HI/LO for DIV instructions in the multicycle CPU.
- Sits beside the ALU: dividend comes from register A, divisor from register B.
- Started by the control FSM (StartDiv). Its outputs feed the HI/LO select muxes in front of the `high`/`low` registers.
- Reports completion (DivEnd) and divide-by-zero (DivZero) back to the control FSM, which raises the exception.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is verified.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend, sampled on the start edge.
- divisor  input  WIDTH  signed divisor, sampled on the start edge.
- hi  output  WIDTH  remainder; registered, holds its value until the next successful division.
- lo  output  WIDTH  quotient; registered, holds its value until the next successful division.
- busy  output  1  high while a division is in progress (RUN or FIX).
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse, coincident with done, when divisor == 0.

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; internal counter, partial remainder and quotient cleared. Reset overrides start on the same edge.
- States: IDLE, RUN, FIX, ZERO.
- IDLE, start=1 and divisor!=0:
  - capture |dividend| into the quotient shift register, |divisor| into the divisor register;
  - capture sign flags qneg = dividend[31]^divisor[31] and rneg = dividend[31];
  - partial remainder=0, count=0; go to RUN; busy=1 from the next cycle.
- IDLE, start=1 and divisor==0:
  - go to ZERO; hi/lo not modified.
- RUN, one restoring step per cycle:
  - shift {rem,quo} left by 1;
  - trial = rem - dsr (33-bit);
  - if trial is non-negative: rem=trial, quo[0]=1; else quo[0]=0;
  - count increments; after the 32nd step (count==31 on that edge) go to FIX.
- FIX:
  - lo = qneg ? -quo : quo;
  - hi = rneg ? -rem : rem;
  - done=1 and busy=0 during the following cycle; go to IDLE.
- ZERO:
  - done=1 and div_zero=1 for one cycle; busy stays 0; go to IDLE.
- Latency: start sampled at edge E0.
  - Normal division: RUN steps on edges E1..E32, FIX on E33, done high between E33 and E34.
  - Divide-by-zero: done/div_zero high between E1 and E2.
- Semantics: quotient truncated toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
- Magnitudes use 33-bit internal arithmetic so that |0x80000000| is represented correctly.
- 0x80000000 / 0xFFFFFFFF: lo=0x80000000 (wraps), hi=0, no flag raised.
- start while busy or during the done cycle: ignored, with no effect on the running operation. A start in the cycle after done (state IDLE) is accepted.
- Operand inputs may change freely after the start edge.
- Reset mid-operation: next cycle state=IDLE, hi/lo=0, busy=0, no done pulse.
- done and div_zero are never high for more than one consecutive cycle.

Test Plan:
- 7 / 2, start at cycle 0 -> busy=1 cycles 1..33; done=1 only in cycle 34; lo=0x00000003, hi=0x00000001; div_zero=0.
- -7 / 2 (0xFFFFFFF9 / 0x00000002) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001. Then -7 / -2 -> lo=0x00000003, hi=0xFFFFFFFF.
- Prior result lo=3, hi=1; then 0x12345678 / 0 -> done=1 and div_zero=1 in cycle 2 only; hi=1, lo=3 unchanged; busy never 1.
- 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Then 0x80000000 / 1 -> lo=0x80000000, hi=0.
- Start 100/7; pulse start with 9/3 at cycle 10 -> ignored; result lo=14, hi=2 at cycle 34. Then 9/3 issued in cycle 35 -> lo=3, hi=0 at cycle 69.
- Start 100/7; assert Reset in cycle 15 -> cycle 16: busy=0, hi=lo=0, no done pulse. Then 100/7 -> lo=14, hi=2 with normal latency.

Source files
------------

// File: rtl/div_if.sv
// div_if: handshake and operand/result bundle between the control FSM and div_unit.
// Ports (signals):
//   start            - single-cycle division request
//   dividend/divisor - signed operands, sampled on the start edge
//   hi/lo            - remainder/quotient results, held until the next successful division
//   busy             - division in progress
//   done             - one-cycle completion pulse
//   div_zero         - one-cycle divide-by-zero pulse, coincident with done
interface div_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;
    modport master (output start, dividend, divisor, input hi, lo, busy, done, div_zero);
    modport slave (input start, dividend, divisor, output hi, lo, busy, done, div_zero);
endinterface

// File: rtl/div_unit.sv
// div_unit: sequential signed restoring divider producing HI (remainder) and LO (quotient).
// Ports:
//   Clk   - clock, all state changes on the rising edge
//   Reset - synchronous active-high reset
//   bus   - div_if slave: start/dividend/divisor in; hi/lo/busy/done/div_zero out
module div_unit #(parameter int WIDTH = 32) (
    input logic Clk,
    input logic Reset,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;
    state_t state;
    logic [WIDTH-1:0] rem, quo, dsr, absDividend, absDivisor, diff;
    logic [WIDTH:0] remShift;
    logic [CW-1:0] count;
    logic qNeg, rNeg, ge;
    // Magnitudes fit in WIDTH unsigned bits (|0x80000000| = 0x80000000), and the
    // partial remainder is always below the divisor magnitude, so the difference
    // only needs WIDTH bits once the comparison has been made at WIDTH+1 bits.
    always_comb begin
        absDividend = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        absDivisor = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
        remShift = {rem, quo[WIDTH-1]};
        ge = remShift >= {1'b0, dsr};
        diff = remShift[WIDTH-1:0] - dsr;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            rem <= '0;
            quo <= '0;
            dsr <= '0;
            count <= '0;
            qNeg <= 1'b0;
            rNeg <= 1'b0;
            bus.hi <= '0;
            bus.lo <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle is also IDLE; a start there is ignored.
                    if (bus.start && !bus.done) begin
                        if (bus.divisor == '0) begin
                            state <= ZERO;
                        end else begin
                            quo <= absDividend;
                            dsr <= absDivisor;
                            qNeg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            rNeg <= bus.dividend[WIDTH-1];
                            rem <= '0;
                            count <= '0;
                            bus.busy <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= ge ? diff : remShift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ge};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    bus.lo <= qNeg ? -quo : quo;
                    bus.hi <= rNeg ? -rem : rem;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                ZERO: begin
                    bus.done <= 1'b1;
                    bus.div_zero <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference.
module tb_div_unit;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;

    div_if #(.WIDTH(32)) bus ();
    div_unit #(.WIDTH(32)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one division starting in the current cycle (called just after a falling edge).
    // injCycle > 0 pulses a competing 9/3 start in that cycle, which must be ignored.
    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input int injCycle);
        longint sa, sb, q, r;
        logic [31:0] expLo, expHi;
        bit zero;
        bit busyOk;
        int cyc, expCyc;
        sa = $signed(a);
        sb = $signed(b);
        zero = (b == 0);
        q = zero ? 0 : sa / sb;
        r = zero ? 0 : sa % sb;
        expLo = zero ? modelLo : q[31:0];
        expHi = zero ? modelHi : r[31:0];
        expCyc = zero ? 2 : 34;
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(negedge Clk);
        bus.start = 1'b0;
        bus.dividend = $urandom;
        bus.divisor = $urandom;
        cyc = 1;
        busyOk = 1'b1;
        while (bus.done !== 1'b1 && cyc < 100) begin
            if (bus.busy !== !zero) busyOk = 1'b0;
            if (cyc == injCycle) begin
                bus.start = 1'b1;
                bus.dividend = 32'd9;
                bus.divisor = 32'd3;
            end
            @(negedge Clk);
            bus.start = 1'b0;
            cyc++;
        end
        chk($sformatf("latency %h/%h", a, b), 32'(cyc), 32'(expCyc));
        chk($sformatf("busy-run %h/%h", a, b), 32'(busyOk), 32'd1);
        chk($sformatf("div_zero %h/%h", a, b), 32'(bus.div_zero), 32'(zero));
        chk($sformatf("lo %h/%h", a, b), bus.lo, expLo);
        chk($sformatf("hi %h/%h", a, b), bus.hi, expHi);
        chk($sformatf("busy-done %h/%h", a, b), 32'(bus.busy), 32'd0);
        modelLo = expLo;
        modelHi = expHi;
        // A start during the done cycle must not launch anything.
        bus.start = 1'b1;
        bus.dividend = $urandom;
        bus.divisor = $urandom | 32'd1;
        @(negedge Clk);
        bus.start = 1'b0;
        chk("done-once", 32'(bus.done), 32'd0);
        chk("div_zero-once", 32'(bus.div_zero), 32'd0);
        chk("start-in-done-ignored", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        bit doneSeen;
        bus.start = 1'b1;
        bus.dividend = 32'd5;
        bus.divisor = 32'd1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        bus.start = 1'b0;
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset div_zero", 32'(bus.div_zero), 32'd0);

        runDiv(32'd7, 32'd2, 0);
        runDiv(32'hFFFFFFF9, 32'd2, 0);
        runDiv(32'd7, 32'hFFFFFFFE, 0);
        runDiv(32'hFFFFFFF9, 32'hFFFFFFFE, 0);
        runDiv(32'd7, 32'd2, 0);
        runDiv(32'h12345678, 32'd0, 0);
        runDiv(32'h80000000, 32'hFFFFFFFF, 0);
        runDiv(32'h80000000, 32'd1, 0);
        runDiv(32'd100, 32'd7, 10);
        runDiv(32'd9, 32'd3, 0);
        runDiv(32'h7FFFFFFF, 32'h80000000, 0);
        runDiv(32'h80000000, 32'h80000000, 0);

        // Reset in the middle of a division.
        bus.start = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor = 32'd7;
        @(negedge Clk);
        bus.start = 1'b0;
        for (int i = 1; i < 15; i++) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset hi", bus.hi, 32'd0);
        chk("midreset lo", bus.lo, 32'd0);
        modelHi = '0;
        modelLo = '0;
        doneSeen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) doneSeen = 1'b1;
            @(negedge Clk);
        end
        chk("midreset quiet", 32'(doneSeen), 32'd0);
        runDiv(32'd100, 32'd7, 0);

        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = -32'($urandom_range(1, 9));
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            runDiv(a, b, (i % 3 == 0) ? int'($urandom_range(1, 33)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
